// File: rtl/seq_pattern_tx_if.sv
// Symbol-transmitter bus: start/abort control with pattern/gap/reps fields
// in, registered one-hot p1/p2 symbol strobes and status out.
interface seq_pattern_tx_if #(
  parameter int PATTERN_W = 4,
  parameter int GAP_W     = 4,
  parameter int REP_W     = 3
) ();
  // Handshake: start is a request taken only when the transmitter is idle and
  // abort is low; the fields are captured on that edge. sym_valid qualifies
  // p1/p2 and there is no backpressure. busy spans SEND/GAP, done pulses once.
  logic                 start;
  logic                 abort;
  logic [PATTERN_W-1:0] pattern;
  logic [GAP_W-1:0]     gap;
  logic [REP_W-1:0]     reps;
  logic                 p1;
  logic                 p2;
  logic                 sym_valid;
  logic                 busy;
  logic                 done;

  modport master (
    output start, abort, pattern, gap, reps,
    input  p1, p2, sym_valid, busy, done
  );

  modport slave (
    input  start, abort, pattern, gap, reps,
    output p1, p2, sym_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first as one-hot
// P1 ("1") / P2 ("0") strobes, with a programmable gap and repeat count.
module seq_pattern_tx #(
  parameter int PATTERN_W = 4,
  parameter int GAP_W     = 4,
  parameter int REP_W     = 3
) (
  input  logic               clk,
  input  logic               reset,
  seq_pattern_tx_if.slave    bus,
  output logic [1:0]         state_dbg
);
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  localparam int CW = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
  localparam logic [CW-1:0] LAST_SYM = CW'(PATTERN_W - 1);

  state_t               state_q, state_d;
  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic [PATTERN_W-1:0] shreg_q, shreg_d;
  logic [GAP_W-1:0]     gapl_q, gapl_d;
  logic [GAP_W-1:0]     gcnt_q, gcnt_d;
  logic [REP_W-1:0]     rep_q, rep_d;
  logic [CW-1:0]        sym_q, sym_d;
  logic                 p1_d, p2_d, sym_valid_d, busy_d, done_d;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    shreg_d = shreg_q;
    gapl_d  = gapl_q;
    gcnt_d  = gcnt_q;
    rep_d   = rep_q;
    sym_d   = sym_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          pat_d   = bus.pattern;
          shreg_d = bus.pattern;
          gapl_d  = bus.gap;
          rep_d   = (bus.reps == '0) ? REP_W'(1) : bus.reps;
          sym_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // Pattern boundary: reload the shifter and consume one repetition.
        if (sym_q == LAST_SYM) begin
          sym_d   = '0;
          shreg_d = pat_q;
          rep_d   = rep_q - 1'b1;
        end else begin
          sym_d   = sym_q + 1'b1;
          shreg_d = {shreg_q[PATTERN_W-2:0], 1'b0};
        end
        if (sym_q == LAST_SYM && rep_q == REP_W'(1)) begin
          state_d = DONE;
        end else if (gapl_q == '0) begin
          state_d = SEND;
        end else begin
          state_d = GAP;
          gcnt_d  = gapl_q;
        end
      end
      GAP: begin
        if (gcnt_q == GAP_W'(1)) state_d = SEND;
        gcnt_d = gcnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort && state_q != IDLE) state_d = IDLE;
  end

  // Outputs are registered copies of what the next state will present.
  always_comb begin
    p1_d        = (state_d == SEND) &&  shreg_d[PATTERN_W-1];
    p2_d        = (state_d == SEND) && !shreg_d[PATTERN_W-1];
    sym_valid_d = (state_d == SEND);
    busy_d      = (state_d == SEND) || (state_d == GAP);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pat_q         <= '0;
      shreg_q       <= '0;
      gapl_q        <= '0;
      gcnt_q        <= '0;
      rep_q         <= '0;
      sym_q         <= '0;
      bus.p1        <= 1'b0;
      bus.p2        <= 1'b0;
      bus.sym_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      shreg_q       <= shreg_d;
      gapl_q        <= gapl_d;
      gcnt_q        <= gcnt_d;
      rep_q         <= rep_d;
      sym_q         <= sym_d;
      bus.p1        <= p1_d;
      bus.p2        <= p2_d;
      bus.sym_valid <= sym_valid_d;
      bus.busy      <= busy_d;
      bus.done      <= done_d;
    end
  end

  assign state_dbg = state_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed transmissions feed an expected-symbol
// queue and an expected-end queue that a negedge monitor drains.
module tb_seq_pattern_tx;
  localparam int PATTERN_W = 4;
  localparam int GAP_W     = 4;
  localparam int REP_W     = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;

  seq_pattern_tx_if #(.PATTERN_W(PATTERN_W), .GAP_W(GAP_W), .REP_W(REP_W)) bus ();

  seq_pattern_tx #(.PATTERN_W(PATTERN_W), .GAP_W(GAP_W), .REP_W(REP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Symbol entry: {idle cycles before symbol, p1, p2}; end entry: {done, busy cycles}.
  logic [GAP_W+1:0] exp_q[$];
  logic [8:0]       end_q[$];
  logic [GAP_W+1:0] sym_exp, sym_got;
  logic [8:0]       end_exp, end_got;
  int               idle_run;
  int               busy_len;
  logic             prev_busy;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      end_q.delete();
      idle_run  = 0;
      busy_len  = 0;
      prev_busy = 1'b0;
    end else begin
      checks++;
      if ((bus.p1 && bus.p2) || (bus.sym_valid != (bus.p1 | bus.p2)) || (bus.done && bus.busy)) begin
        errors++;
        $display("FAIL invariant: p1=%b p2=%b sym_valid=%b busy=%b done=%b", bus.p1, bus.p2,
                 bus.sym_valid, bus.busy, bus.done);
      end
      if (bus.sym_valid) begin
        checks++;
        sym_got = {GAP_W'(idle_run), bus.p1, bus.p2};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL symbol: unexpected {gap,p1,p2}=%h, none expected", sym_got);
        end else begin
          sym_exp = exp_q.pop_front();
          if (sym_got !== sym_exp) begin
            errors++;
            $display("FAIL symbol: got {gap,p1,p2}=%h expected %h", sym_got, sym_exp);
          end
        end
        idle_run = 0;
        busy_len++;
      end else if (bus.busy) begin
        idle_run++;
        busy_len++;
      end
      if ((!bus.busy && prev_busy) || bus.done) begin
        checks++;
        end_got = {bus.done, 8'(busy_len)};
        if (end_q.size() == 0) begin
          errors++;
          $display("FAIL end: unexpected {done,busy_len}=%h, none expected", end_got);
        end else begin
          end_exp = end_q.pop_front();
          if (end_got !== end_exp) begin
            errors++;
            $display("FAIL end: got {done,busy_len}=%h expected %h", end_got, end_exp);
          end
        end
        busy_len = 0;
        idle_run = 0;
      end
      prev_busy = bus.busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_pattern(input logic [PATTERN_W-1:0] pat, input logic [GAP_W-1:0] g,
                              input logic [REP_W-1:0] r);
    int rr;
    int n_sym;
    logic first;
    logic b;
    rr    = (r == 0) ? 1 : int'(r);
    first = 1'b1;
    for (int k = 0; k < rr; k++) begin
      for (int i = PATTERN_W - 1; i >= 0; i--) begin
        b = pat[i];
        exp_q.push_back({(first ? GAP_W'(0) : g), b, ~b});
        first = 1'b0;
      end
    end
    n_sym = PATTERN_W * rr;
    end_q.push_back({1'b1, 8'(n_sym + int'(g) * (n_sym - 1))});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(posedge clk); #1;
      if (!bus.busy && !bus.done) break;
      n++;
      if (n > 400) begin
        checks++;
        errors++;
        $display("FAIL timeout: busy=%b done=%b still active after 400 cycles", bus.busy, bus.done);
        break;
      end
    end
  endtask

  // Called just after a rising edge with the transmitter idle.
  task automatic send(input logic [PATTERN_W-1:0] pat, input logic [GAP_W-1:0] g,
                      input logic [REP_W-1:0] r);
    push_pattern(pat, g, r);
    bus.pattern = pat;
    bus.gap     = g;
    bus.reps    = r;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.pattern = PATTERN_W'($urandom_range(0, (1 << PATTERN_W) - 1));
    bus.gap     = GAP_W'($urandom_range(0, (1 << GAP_W) - 1));
    bus.reps    = REP_W'($urandom_range(0, (1 << REP_W) - 1));
    wait_idle();
  endtask

  task automatic check_quiet(input string name);
    logic [4:0] got;
    @(negedge clk);
    got = {bus.p1, bus.p2, bus.sym_valid, bus.busy, bus.done};
    checks++;
    if (got !== 5'b0) begin
      errors++;
      $display("FAIL %s: {p1,p2,sym_valid,busy,done}=%b expected 00000", name, got);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] outs;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.pattern = '0;
    bus.gap     = '0;
    bus.reps    = '0;
    #12 reset = 1'b0;
    for (int i = 0; i < 10; i++) check_quiet("reset_idle");

    send(4'b1100, 4'd0, 3'd1);
    send(4'b1010, 4'd2, 3'd2);
    send(4'b1001, 4'd0, 3'd0);
    send(4'b1110, 4'd0, 3'd7);
    send(4'b0110, 4'd1, 3'd3);

    // Start held high and pattern changed during an active 1100 transmission.
    push_pattern(4'b1100, 4'd0, 3'd1);
    bus.pattern = 4'b1100;
    bus.gap     = 4'd0;
    bus.reps    = 3'd1;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.pattern = 4'b0011;
    repeat (5) @(posedge clk);
    #1 bus.start = 1'b0;
    wait_idle();
    check_quiet("no_restart");
    check_quiet("no_restart");

    // Abort in the first gap cycle after symbol 2: 8 busy cycles, no done.
    exp_q.push_back({GAP_W'(0), 1'b1, 1'b0});
    exp_q.push_back({GAP_W'(2), 1'b0, 1'b1});
    exp_q.push_back({GAP_W'(2), 1'b1, 1'b0});
    end_q.push_back({1'b0, 8'd8});
    bus.pattern = 4'b1010;
    bus.gap     = 4'd2;
    bus.reps    = 3'd1;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check_quiet("after_abort");
    send(4'b0101, 4'd0, 3'd1);

    // Abort held with start in idle blocks the start.
    bus.pattern = 4'b1111;
    bus.start   = 1'b1;
    bus.abort   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_quiet("abort_blocks_start");

    // Asynchronous reset mid-SEND: outputs clear before the next edge.
    push_pattern(4'b1100, 4'd0, 3'd3);
    bus.pattern = 4'b1100;
    bus.gap     = 4'd0;
    bus.reps    = 3'd3;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    outs = {bus.p1, bus.p2, bus.sym_valid, bus.busy, bus.done};
    checks++;
    if (outs !== 5'b0) begin
      errors++;
      $display("FAIL async_reset: {p1,p2,sym_valid,busy,done}=%b expected 00000", outs);
    end
    #5 reset = 1'b0;
    @(posedge clk); #1;
    check_quiet("after_reset");
    send(4'b1100, 4'd0, 3'd1);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0 || end_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d symbols and %0d ends still expected, required 0 and 0",
               exp_q.size(), end_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter for the push-button symbol interface. P1 carries a "1" symbol and P2 carries a "0" symbol.
- On a start request it captures a PATTERN_W-bit pattern and drives it MSB-first as one-hot P1/P2 symbol cycles.
- It supports a programmable idle gap between symbols and a programmable repeat count.
- It stimulates the sequence-detector side of the interface (e.g. default pattern 1100 → P1,P1,P2,P2) and can replace manual button pulses on the board.

Parameters:
PATTERN_W, 4, number of symbols per pattern (≥2)
GAP_W, 4, width of gap-length field (idle cycles between symbols)
REP_W, 3, width of repeat-count field

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state and outputs
start  in  1  request; sampled only in IDLE
abort  in  1  synchronous cancel; honoured in any non-IDLE state
pattern  in  PATTERN_W  symbols, MSB sent first; 1→P1, 0→P2
gap  in  GAP_W  idle cycles inserted between consecutive symbols
reps  in  REP_W  pattern transmissions; 0 treated as 1
p1  out  1  "1" symbol strobe (registered)
p2  out  1  "0" symbol strobe (registered)
sym_valid  out  1  high exactly when p1 or p2 is high
busy  out  1  high in SEND and GAP
done  out  1  one-cycle pulse after final symbol

Behaviour:
- Reset: asynchronous, active-high; clock clk.
  - State → IDLE.
  - p1, p2, sym_valid, busy, done all 0.
  - Internal shift register and counters cleared.
  - Reset mid-transmission drops outputs to 0 immediately (asynchronous); no done is issued.
- All outputs are registered (Moore). p1 and p2 are never high together.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - Outputs 0.
  - start=1 at edge E0 captures pattern, gap, and max(reps,1), then enters SEND.
  - Latency: symbol 0 is visible in the cycle after E0.
- SEND (one cycle per symbol):
  - p1 = shreg[MSB], p2 = ~shreg[MSB], sym_valid=1, busy=1.
  - At the edge, shreg shifts left (reloaded from the captured pattern at pattern boundaries).
  - Symbol counter increments; at PATTERN_W it wraps to 0 and the remaining-reps counter decrements.
  - If that was the last symbol of the last repetition → DONE.
  - Else if gap=0 → SEND (back-to-back symbols, no idle cycle, including across pattern boundaries).
  - Else → GAP.
- GAP:
  - p1=p2=sym_valid=0, busy=1.
  - Counts exactly `gap` cycles, then → SEND.
- DONE:
  - done=1 for exactly one cycle; busy=0; symbol outputs 0.
  - → IDLE.
  - start during DONE is ignored (no back-to-back overlap).
- Total busy cycles = N*R + G*(N*R−1), with N=PATTERN_W, R=max(reps,1), G=gap.
- start while busy or in DONE: ignored.
- Input changes after capture: pattern, gap and reps have no effect until the next start.
- abort=1 in SEND, GAP or DONE:
  - Next state is IDLE; all outputs 0 in the following cycle; no done pulse.
  - abort has priority over start and over the normal transition.
- abort in IDLE: no effect; if start is also high, start is still accepted unless abort is asserted.
  - Rule: abort high blocks start in the same cycle.
- reps counter saturates correctly at the maximum field value (7 → 7 transmissions); no wrap.

Test Plan:
- Reset then idle: reset pulse mid-cycle, start=0 for 10 cycles → p1=p2=sym_valid=busy=done=0 throughout.
- Basic transmission: pattern=4'b1100, gap=0, reps=1, start at E0 → cycles after E0..E3 show p1,p1,p2,p2 (sym_valid=1, busy=1); done=1 exactly in the cycle after E4; IDLE in the cycle after E5. A 1100 Moore detector driven by p1/p2 asserts its output in the cycle after E4.
- Gap and repeat: pattern=4'b1010, gap=2, reps=2 → symbols 1,0,1,0,1,0,1,0, each separated by exactly 2 all-zero cycles; busy high for 8+2*7=22 cycles; single done pulse.
- reps=0 and max: reps=0 → exactly one pattern (4 symbols); reps=7, gap=0 → 28 consecutive symbols, then done.
- Ignored start and input changes: assert start and change pattern to 4'b0011 during an active 1100 transmission → output remains 1100; no restart; one done.
- Abort and async reset: abort in the GAP cycle after symbol 2 → next cycle all outputs 0, no done, IDLE accepts a new start. Async reset asserted during SEND mid-cycle → outputs 0 before the next clock edge.
